// File: rtl/inst_rom_arbiter.sv
// Weighted round-robin arbiter sharing one combinational instruction ROM between
// the IF-stage fetch (port 0, flushable) and the debug/loader read port (port 1).
module inst_rom_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WEIGHT0 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_flush,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam logic [3:0] WEIGHT_LIM = 4'(WEIGHT0);

  logic [3:0] cnt0;
  logic       pend0;
  logic       pend1;

  // Port 0 wins unless port 1 has already waited out WEIGHT0 port-0 grants.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && (!m1_req || cnt0 != WEIGHT_LIM)) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rom_ce   = m0_gnt | m1_gnt;
    rom_addr = '0;
    if (m0_gnt) begin
      rom_addr = m0_addr;
    end else if (m1_gnt) begin
      rom_addr = m1_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      cnt0     <= 4'd0;
    end else begin
      pend0 <= m0_gnt;
      pend1 <= m1_gnt;
      if (m0_gnt) begin
        m0_rdata <= rom_inst;
      end
      if (m1_gnt) begin
        m1_rdata <= rom_inst;
      end
      if (!m1_req || m1_gnt) begin
        cnt0 <= 4'd0;
      end else if (m0_gnt) begin
        cnt0 <= cnt0 + 4'd1;
      end
    end
  end

  // Masking with rst kills a response whose grant landed the cycle before reset.
  assign m0_rvalid = pend0 & ~m0_flush & ~rst;
  assign m1_rvalid = pend1 & ~rst;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed-vector bench for inst_rom_arbiter: grant/ROM-drive checks per cycle,
// read responses checked through per-port scoreboards by a separate monitor.
module tb_inst_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_flush, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rom_ce;
  logic [31:0] m0_rdata, m1_rdata, rom_addr, rom_inst;

  logic [31:0] rom [256];
  assign rom_inst = rom[rom_addr[9:2]];

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .WEIGHT0(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_flush(m0_flush), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        fl;
    logic        r1;
    logic [31:0] a1;
    logic        g0;
    logic        g1;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic r0, input logic [31:0] a0, input logic fl,
                     input logic r1, input logic [31:0] a1, input logic g0, input logic g1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.a0 = a0; v.fl = fl;
    v.r1 = r1; v.a1 = a1; v.g0 = g0; v.g1 = g1;
    vecs.push_back(v);
  endtask

  // Response monitor: every cycle, an entry due now must appear and nothing else may.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        check("m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check("m0_rdata", m0_rdata, q0[0].data);
        void'(q0.pop_front());
      end else if (m0_rvalid) begin
        check("m0_rvalid_spurious", {31'd0, m0_rvalid}, 32'd0);
      end
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        check("m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
        check("m1_rdata", m1_rdata, q1[0].data);
        void'(q1.pop_front());
      end else if (m1_rvalid) begin
        check("m1_rvalid_spurious", {31'd0, m1_rvalid}, 32'd0);
      end
    end
  end

  initial begin
    vec_t v, nx;
    exp_t e;
    logic [31:0] exp_addr;
    for (int k = 0; k < 256; k++) rom[k] = 32'h1000_0000 + k * 32'h0001_0011;
    rom[2]  = 32'h3401_1100;
    rom[16] = 32'hDEAD_0010;

    //  rst r0  a0           fl  r1  a1           g0  g1
    add(1, 1, 32'h0000_0008, 0, 1, 32'h0000_0080, 0, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,         0, 0);
    add(0, 1, 32'h0000_0008, 0, 0, 32'h0,         1, 0);  // single port 0
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0);
    for (int k = 0; k < 10; k++) begin                      // weighted contention
      add(0, 1, 32'h0000_0040 + 32'(k * 4), 0, 1, 32'h0000_0080,
          (k == 4 || k == 9) ? 1'b0 : 1'b1, (k == 4 || k == 9) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 8; k++) begin                       // port 1 idle, streaming
      add(0, 1, 32'(k * 4), 0, 0, 32'h0, 1, 0);
    end
    add(0, 1, 32'h0000_0010, 0, 0, 32'h0,         1, 0);  // flush
    add(0, 1, 32'h0000_0040, 1, 0, 32'h0,         1, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h0000_0030, 0, 1);  // port 1 through flush
    add(0, 0, 32'h0,         1, 0, 32'h0,         0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h0000_0020, 0, 1);  // reset mid-op
    add(1, 1, 32'h0000_0004, 0, 1, 32'h0000_0020, 0, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,         0, 0);
    for (int k = 0; k < 5; k++) begin                       // cnt0 restarts at 0
      add(0, 1, 32'h0000_0004, 0, 1, 32'h0000_0024,
          (k == 4) ? 1'b0 : 1'b1, (k == 4) ? 1'b1 : 1'b0);
    end
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h0000_001E, 0, 1);  // misaligned pass-through
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      rst = v.rst; m0_req = v.r0; m0_addr = v.a0; m0_flush = v.fl;
      m1_req = v.r1; m1_addr = v.a1;
      cyc = i;
      if (i + 1 < vecs.size()) nx = vecs[i + 1];
      else begin nx = v; nx.rst = 0; nx.fl = 0; end
      if (v.g0 && !nx.fl && !nx.rst) begin
        e.due = i + 1; e.data = rom[v.a0[9:2]]; q0.push_back(e);
      end
      if (v.g1 && !nx.rst) begin
        e.due = i + 1; e.data = rom[v.a1[9:2]]; q1.push_back(e);
      end
      exp_addr = v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'h0);
      @(negedge clk);
      check("gnt", {30'd0, m0_gnt, m1_gnt}, {30'd0, v.g0, v.g1});
      check("rom_ce", {31'd0, rom_ce}, {31'd0, v.g0 | v.g1});
      check("rom_addr", rom_addr, exp_addr);
      if (i == 1) begin
        check("m0_rdata_reset", m0_rdata, 32'h0);
        check("m1_rdata_reset", m1_rdata, 32'h0);
      end
    end
    @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
